// File: rtl/cpu_types_pkg.sv
// Shared CPU/cache types.
//   word_t    : one data/address word (WORD_W bits)
//   msi_t     : MSI line state as stored in the dcache tag array
//   blk_word  : byte address of word 0 or word 1 of a 2-word block
package cpu_types_pkg;
  localparam int WORD_W    = 32;
  localparam int BLK_OFF   = 3;   // byte-offset bits of a block
  localparam int BLK_WORDS = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_t;

  // Clears the block offset of base, then selects word 0 (+0) or word 1 (+4).
  function automatic word_t blk_word(input word_t base, input logic second);
    word_t w_mask;
    w_mask = word_t'((1 << BLK_OFF) - 1);
    return (base & ~w_mask) | (second ? word_t'(4) : word_t'(0));
  endfunction
endpackage

// File: rtl/coherence_snoop_resp.sv
// Snoop responder: answers coherence-controller snoops for one L1 dcache.
// Ports:
//   CLK, nRST                   clock, async active-low reset
//   i_ccwait, i_ccinv           snoop in progress / invalidating snoop
//   i_ccsnoopaddr               snooped block address
//   i_dwait                     bus word not yet complete
//   i_snp_state, i_snp_d0/d1    tag-array lookup result for o_snp_addr
//   o_snp_addr                  latched snoop address to the tag array
//   o_snp_we, o_snp_new         one-cycle MSI state update
//   o_cctrans, o_ccwrite        snoop response (1/1 = supplying M data)
//   o_dwen, o_daddr, o_dstore   bus write of the Modified block
module coherence_snoop_resp
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       i_ccwait,
  input  logic       i_ccinv,
  input  word_t      i_ccsnoopaddr,
  input  logic       i_dwait,
  input  logic [1:0] i_snp_state,
  input  word_t      i_snp_d0,
  input  word_t      i_snp_d1,
  output word_t      o_snp_addr,
  output logic       o_snp_we,
  output logic [1:0] o_snp_new,
  output logic       o_cctrans,
  output logic       o_ccwrite,
  output logic       o_dwen,
  output word_t      o_daddr,
  output word_t      o_dstore
);
  typedef enum logic [2:0] {SIDLE, SCHK, SSEND0, SSEND1, SUPD} snp_fsm_t;

  snp_fsm_t r_state, w_next;
  word_t    r_addr;
  logic     r_inv;
  msi_t     r_seen;      // line state observed during the lookup cycle
  logic     r_upd_done;  // SUPD already spent its single write cycle

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= SIDLE;
      r_addr     <= '0;
      r_inv      <= 1'b0;
      r_seen     <= MSI_I;
      r_upd_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      if (r_state == SIDLE && i_ccwait) begin
        r_addr <= i_ccsnoopaddr;
        r_inv  <= i_ccinv;
      end
      if (r_state == SCHK) r_seen <= msi_t'(i_snp_state);
      r_upd_done <= (r_state == SUPD);
    end
  end

  always_comb begin
    w_next    = r_state;
    o_snp_we  = 1'b0;
    o_snp_new = MSI_I;
    o_cctrans = 1'b0;
    o_ccwrite = 1'b0;
    o_dwen    = 1'b0;
    o_daddr   = '0;
    o_dstore  = '0;
    case (r_state)
      SIDLE: if (i_ccwait) w_next = SCHK;
      SCHK: begin
        if (i_snp_state == MSI_M) begin
          o_cctrans = 1'b1;
          o_ccwrite = 1'b1;
          w_next    = SSEND0;
        end else begin
          w_next = SUPD;
        end
      end
      SSEND0, SSEND1: begin
        o_cctrans = 1'b1;
        o_ccwrite = 1'b1;
        o_dwen    = 1'b1;
        o_daddr   = blk_word(r_addr, r_state == SSEND1);
        o_dstore  = (r_state == SSEND1) ? i_snp_d1 : i_snp_d0;
        // Controller withdrawing the snoop mid-transfer aborts without a state update.
        if (!i_ccwait)     w_next = SIDLE;
        else if (!i_dwait) w_next = (r_state == SSEND0) ? SSEND1 : SUPD;
      end
      SUPD: begin
        if (!r_upd_done) begin
          if (r_inv && r_seen != MSI_I) begin
            o_snp_we  = 1'b1;
            o_snp_new = MSI_I;
          end else if (!r_inv && r_seen == MSI_M) begin
            o_snp_we  = 1'b1;
            o_snp_new = MSI_S;
          end
        end
        if (!i_ccwait) w_next = SIDLE;
      end
      default: w_next = SIDLE;
    endcase
  end

  assign o_snp_addr = r_addr;
endmodule

// File: rtl/dcache_coherence_agent.sv
// Cache-side coherence bus agent for one L1 dcache.
// Request path: optional dirty-victim writeback (2 words, cctrans=0), then a
// 2-word block fetch announced with cctrans=1 / ccwrite=req_write, then a
// one-cycle req_done with the fetched block and the MSI state to install.
// Snoop path lives in coherence_snoop_resp; ccwait selects which side owns
// the bus outputs.
// Ports: CLK/nRST; req_* and victim_* from the dcache miss logic; req_done,
// fill_d0/d1, fill_state back to it; snp_* to/from the tag/data arrays;
// dREN/dWEN/daddr/dstore/dload/dwait and cctrans/ccwrite/ccwait/ccinv/
// ccsnoopaddr to the memory/coherence controller.
module dcache_coherence_agent
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       req_valid,
  input  logic       req_write,
  input  word_t      req_addr,
  input  logic       victim_dirty,
  input  word_t      victim_addr,
  input  word_t      victim_d0,
  input  word_t      victim_d1,
  output logic       req_done,
  output word_t      fill_d0,
  output word_t      fill_d1,
  output logic [1:0] fill_state,
  output word_t      snp_addr,
  input  logic [1:0] snp_state,
  input  word_t      snp_d0,
  input  word_t      snp_d1,
  output logic       snp_we,
  output logic [1:0] snp_new,
  output logic       dREN,
  output logic       dWEN,
  output word_t      daddr,
  output word_t      dstore,
  input  word_t      dload,
  input  logic       dwait,
  output logic       cctrans,
  output logic       ccwrite,
  input  logic       ccwait,
  input  logic       ccinv,
  input  word_t      ccsnoopaddr
);
  typedef enum logic [2:0] {RIDLE, WB0, WB1, FETCH0, FETCH1, RDONE} req_fsm_t;

  req_fsm_t r_state, w_next;
  logic     r_write;
  word_t    r_addr, r_vaddr, r_vd0, r_vd1, r_fill0, r_fill1;

  // Request-side bus drive, before the ownership mux
  logic  w_req_dren, w_req_dwen, w_req_trans, w_req_wr;
  word_t w_req_addr, w_req_store;
  // Snoop-side bus drive
  logic  w_snp_trans, w_snp_wr, w_snp_dwen;
  word_t w_snp_addr, w_snp_store;

  // While the other cache owns the bus the request side is frozen and
  // any dwait it sees belongs to the snoop transfer.
  logic w_adv;
  assign w_adv = !ccwait && !dwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RIDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_vaddr <= '0;
      r_vd0   <= '0;
      r_vd1   <= '0;
      r_fill0 <= '0;
      r_fill1 <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RIDLE && req_valid && !ccwait) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_vaddr <= victim_addr;
        r_vd0   <= victim_d0;
        r_vd1   <= victim_d1;
      end
      if (w_adv && r_state == FETCH0) r_fill0 <= dload;
      if (w_adv && r_state == FETCH1) r_fill1 <= dload;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req_dren  = 1'b0;
    w_req_dwen  = 1'b0;
    w_req_trans = 1'b0;
    w_req_wr    = 1'b0;
    w_req_addr  = '0;
    w_req_store = '0;
    req_done    = 1'b0;
    fill_state  = MSI_I;
    case (r_state)
      RIDLE: if (req_valid && !ccwait) w_next = victim_dirty ? WB0 : FETCH0;
      WB0, WB1: begin
        w_req_dwen  = 1'b1;
        w_req_addr  = blk_word(r_vaddr, r_state == WB1);
        w_req_store = (r_state == WB1) ? r_vd1 : r_vd0;
        if (w_adv) w_next = (r_state == WB0) ? WB1 : FETCH0;
      end
      FETCH0, FETCH1: begin
        w_req_dren  = 1'b1;
        w_req_trans = 1'b1;
        w_req_wr    = r_write;
        w_req_addr  = blk_word(r_addr, r_state == FETCH1);
        if (w_adv) w_next = (r_state == FETCH0) ? FETCH1 : RDONE;
      end
      RDONE: begin
        // Held (no pulse) while frozen so req_done stays a single cycle.
        if (!ccwait) begin
          req_done   = 1'b1;
          fill_state = r_write ? MSI_M : MSI_S;
          w_next     = RIDLE;
        end
      end
      default: w_next = RIDLE;
    endcase
  end

  coherence_snoop_resp u_snoop (
    .CLK          (CLK),
    .nRST         (nRST),
    .i_ccwait     (ccwait),
    .i_ccinv      (ccinv),
    .i_ccsnoopaddr(ccsnoopaddr),
    .i_dwait      (dwait),
    .i_snp_state  (snp_state),
    .i_snp_d0     (snp_d0),
    .i_snp_d1     (snp_d1),
    .o_snp_addr   (snp_addr),
    .o_snp_we     (snp_we),
    .o_snp_new    (snp_new),
    .o_cctrans    (w_snp_trans),
    .o_ccwrite    (w_snp_wr),
    .o_dwen       (w_snp_dwen),
    .o_daddr      (w_snp_addr),
    .o_dstore     (w_snp_store)
  );

  // Bus ownership mux
  always_comb begin
    if (ccwait) begin
      dREN    = 1'b0;
      dWEN    = w_snp_dwen;
      cctrans = w_snp_trans;
      ccwrite = w_snp_wr;
      daddr   = w_snp_addr;
      dstore  = w_snp_store;
    end else begin
      dREN    = w_req_dren;
      dWEN    = w_req_dwen;
      cctrans = w_req_trans;
      ccwrite = w_req_wr;
      daddr   = w_req_addr;
      dstore  = w_req_store;
    end
  end

  assign fill_d0 = r_fill0;
  assign fill_d1 = r_fill1;
endmodule

// File: tb/tb_dcache_coherence_agent.sv
`timescale 1ns/1ps
module tb_dcache_coherence_agent;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       req_valid = 1'b0, req_write = 1'b0, victim_dirty = 1'b0;
  word_t      req_addr = '0, victim_addr = '0, victim_d0 = '0, victim_d1 = '0;
  logic       req_done;
  word_t      fill_d0, fill_d1;
  logic [1:0] fill_state;
  word_t      snp_addr;
  logic [1:0] snp_state = 2'b00;
  word_t      snp_d0 = '0, snp_d1 = '0;
  logic       snp_we;
  logic [1:0] snp_new;
  logic       dREN, dWEN;
  word_t      daddr, dstore;
  word_t      dload = '0;
  logic       dwait = 1'b1;
  logic       cctrans, ccwrite;
  logic       ccwait = 1'b0, ccinv = 1'b0;
  word_t      ccsnoopaddr = '0;

  always #5 CLK = ~CLK;

  dcache_coherence_agent dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .victim_d0(victim_d0), .victim_d1(victim_d1),
    .req_done(req_done), .fill_d0(fill_d0), .fill_d1(fill_d1), .fill_state(fill_state),
    .snp_addr(snp_addr), .snp_state(snp_state), .snp_d0(snp_d0), .snp_d1(snp_d1),
    .snp_we(snp_we), .snp_new(snp_new),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Request: a list of bus beats (writeback words, then fetch words) walked
  // one per completed word while the bus is ours; then one done cycle.
  logic  m_active = 1'b0, m_wr = 1'b0;
  int    m_idx = 0, m_nw = 0;
  word_t m_raddr = '0, m_vaddr = '0, m_vd0 = '0, m_vd1 = '0;
  word_t m_fill[2] = '{default: '0};
  // Snoop: 0 idle, 1 lookup, 2 sending word s_k, 3 update cycle, 4 hold
  int    sp = 0, s_k = 0;
  word_t s_addr = '0;
  logic  s_inv = 1'b0;
  logic [1:0] s_st = 2'b00;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_active <= 1'b0; m_idx <= 0; m_nw <= 0; m_wr <= 1'b0;
      m_raddr <= '0; m_vaddr <= '0; m_vd0 <= '0; m_vd1 <= '0;
      m_fill[0] <= '0; m_fill[1] <= '0;
      sp <= 0; s_k <= 0; s_addr <= '0; s_inv <= 1'b0; s_st <= 2'b00;
    end else begin
      if (!ccwait) begin
        if (!m_active) begin
          if (req_valid) begin
            m_active <= 1'b1; m_idx <= 0; m_nw <= victim_dirty ? 2 : 0;
            m_wr <= req_write; m_raddr <= req_addr; m_vaddr <= victim_addr;
            m_vd0 <= victim_d0; m_vd1 <= victim_d1;
          end
        end else if (m_idx == m_nw + 2) begin
          m_active <= 1'b0;
        end else if (!dwait) begin
          if (m_idx >= m_nw) m_fill[m_idx - m_nw] <= dload;
          m_idx <= m_idx + 1;
        end
      end
      case (sp)
        0: if (ccwait) begin s_addr <= ccsnoopaddr; s_inv <= ccinv; sp <= 1; end
        1: begin
          s_st <= snp_state;
          if (snp_state == 2'b10) begin sp <= 2; s_k <= 0; end else sp <= 3;
        end
        2: if (!ccwait) sp <= 0;
           else if (!dwait) begin if (s_k == 1) sp <= 3; s_k <= s_k + 1; end
        3: sp <= ccwait ? 4 : 0;
        default: if (!ccwait) sp <= 0;
      endcase
    end
  end

  // One compare process: every cycle, on the falling edge.
  always @(negedge CLK) begin : cmp
    logic e_dren, e_dwen, e_trans, e_wr, e_done, e_we;
    word_t e_addr, e_store;
    logic [1:0] e_fs, e_new;
    e_dren = 0; e_dwen = 0; e_trans = 0; e_wr = 0; e_done = 0; e_we = 0;
    e_addr = '0; e_store = '0; e_fs = 2'b00; e_new = 2'b00;
    if (ccwait) begin
      if (sp == 1 && snp_state == 2'b10) begin e_trans = 1; e_wr = 1; end
      if (sp == 2) begin
        e_trans = 1; e_wr = 1; e_dwen = 1;
        e_addr = s_addr + word_t'(4 * s_k);
        e_store = (s_k == 1) ? snp_d1 : snp_d0;
      end
    end else if (m_active && m_idx < m_nw + 2) begin
      if (m_idx < m_nw) begin
        e_dwen = 1; e_addr = m_vaddr + word_t'(4 * m_idx);
        e_store = (m_idx == 1) ? m_vd1 : m_vd0;
      end else begin
        e_dren = 1; e_trans = 1; e_wr = m_wr;
        e_addr = m_raddr + word_t'(4 * (m_idx - m_nw));
      end
    end
    if (!ccwait && m_active && m_idx == m_nw + 2) begin
      e_done = 1; e_fs = m_wr ? 2'b10 : 2'b01;
    end
    if (sp == 3) begin
      e_we = (s_inv && s_st != 2'b00) || (!s_inv && s_st == 2'b10);
      if (e_we) e_new = s_inv ? 2'b00 : 2'b01;
    end
    chk("dREN", 32'(dREN), 32'(e_dren));
    chk("dWEN", 32'(dWEN), 32'(e_dwen));
    chk("cctrans", 32'(cctrans), 32'(e_trans));
    chk("ccwrite", 32'(ccwrite), 32'(e_wr));
    chk("daddr", daddr, e_addr);
    chk("dstore", dstore, e_store);
    chk("req_done", 32'(req_done), 32'(e_done));
    chk("fill_state", 32'(fill_state), 32'(e_fs));
    chk("fill_d0", fill_d0, m_fill[0]);
    chk("fill_d1", fill_d1, m_fill[1]);
    chk("snp_we", 32'(snp_we), 32'(e_we));
    chk("snp_new", 32'(snp_new), 32'(e_new));
    chk("snp_addr", snp_addr, s_addr);
  end

  // ---------------- stimulus ----------------
  logic  dw_toggle = 1'b0;
  word_t dload_base = '0;

  task automatic refresh();
    dload = dload_base | (daddr & 32'h4);
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
    if (dw_toggle) dwait = ~dwait;
    refresh();
  endtask

  task automatic wait_done(input int max, output int n);
    logic ok;
    ok = 1'b0; n = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge CLK);
      if (req_done) begin ok = 1'b1; n = i; req_valid = 1'b0; end
      else cyc();
    end
    chk("req_done_seen", 32'(ok), 32'd1);
  endtask

  task automatic snoop(input word_t a, input logic inv, input logic [1:0] st,
                       input word_t d0, input word_t d1, input int hold,
                       output int nwen, output int nwe, output logic [1:0] lastnew);
    ccsnoopaddr = a; ccinv = inv; snp_state = st; snp_d0 = d0; snp_d1 = d1;
    ccwait = 1'b1; nwen = 0; nwe = 0; lastnew = 2'b11;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (dWEN) nwen++;
      if (snp_we) begin nwe++; lastnew = snp_new; end
      cyc();
    end
    ccwait = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (snp_we) nwe++;
      cyc();
    end
  endtask

  int n, nwen, nwe, nbad;
  logic [1:0] lastnew;

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_req_done", 32'(req_done), 32'd0);
    chk("rst_dREN", 32'(dREN), 32'd0);
    chk("rst_cctrans", 32'(cctrans), 32'd0);
    chk("rst_snp_addr", snp_addr, 32'd0);
    @(posedge CLK); #1; nRST = 1'b1;
    cyc();

    // Clean load miss at 0x100, dwait low every second cycle
    dw_toggle = 1'b1; dwait = 1'b1; dload_base = 32'hAAAA0000;
    req_addr = 32'h100; req_write = 1'b0; victim_dirty = 1'b0; req_valid = 1'b1;
    wait_done(40, n);
    chk("t1_fill_d0", fill_d0, 32'hAAAA0000);
    chk("t1_fill_d1", fill_d1, 32'hAAAA0004);
    chk("t1_fill_state", 32'(fill_state), 32'd1);
    dw_toggle = 1'b0; dwait = 1'b0;
    cyc(); cyc();

    // Store miss at 0x200 with dirty victim 0x80 (0x11, 0x22)
    dload_base = 32'hBBBB0000;
    req_addr = 32'h200; req_write = 1'b1; victim_dirty = 1'b1;
    victim_addr = 32'h80; victim_d0 = 32'h11; victim_d1 = 32'h22; req_valid = 1'b1;
    wait_done(40, n);
    chk("t2_latency", 32'(n), 32'd5);
    chk("t2_fill_state", 32'(fill_state), 32'd2);
    chk("t2_fill_d1", fill_d1, 32'hBBBB0004);
    victim_dirty = 1'b0; req_write = 1'b0;
    cyc(); cyc();

    // Snoop 0x300, BusRd on an M line -> supply data, downgrade to S
    snoop(32'h300, 1'b0, 2'b10, 32'h5, 32'h6, 6, nwen, nwe, lastnew);
    chk("t3_dwen_beats", 32'(nwen), 32'd2);
    chk("t3_we_count", 32'(nwe), 32'd1);
    chk("t3_snp_new", 32'(lastnew), 32'd1);
    chk("t3_snp_addr", snp_addr, 32'h300);

    // Invalidating snoop on S -> invalidate, no data
    snoop(32'h300, 1'b1, 2'b01, 32'h5, 32'h6, 5, nwen, nwe, lastnew);
    chk("t4_dwen_beats", 32'(nwen), 32'd0);
    chk("t4_we_count", 32'(nwe), 32'd1);
    chk("t4_snp_new", 32'(lastnew), 32'd0);
    // Same on an I line -> nothing to update
    snoop(32'h300, 1'b1, 2'b00, 32'h5, 32'h6, 5, nwen, nwe, lastnew);
    chk("t4b_we_count", 32'(nwe), 32'd0);

    // Request while the other cache owns the bus
    dload_base = 32'hCCCC0000;
    ccsnoopaddr = 32'h900; ccinv = 1'b0; snp_state = 2'b00; ccwait = 1'b1;
    req_addr = 32'h400; req_valid = 1'b1; nbad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (dREN || cctrans) nbad++;
      cyc();
    end
    chk("t5_no_fetch_while_snooped", 32'(nbad), 32'd0);
    ccwait = 1'b0;
    wait_done(20, n);
    chk("t5_fill_d0", fill_d0, 32'hCCCC0000);
    chk("t5_fill_d1", fill_d1, 32'hCCCC0004);
    cyc();

    // Snoop arriving mid-fetch: word 0 kept, fetch resumes after
    dload_base = 32'hDDDD0000;
    req_addr = 32'h600; req_valid = 1'b1;
    cyc(); cyc();
    ccsnoopaddr = 32'h900; snp_state = 2'b00; ccwait = 1'b1;
    cyc(); cyc(); cyc();
    @(negedge CLK);
    chk("t6_frozen_dREN", 32'(dREN), 32'd0);
    chk("t6_kept_d0", fill_d0, 32'hDDDD0000);
    @(posedge CLK); #1;
    ccwait = 1'b0; #1; refresh();
    wait_done(20, n);
    chk("t6_fill_d1", fill_d1, 32'hDDDD0004);
    cyc();

    // Reset pulsed during FETCH1
    dload_base = 32'hEEEE0000;
    req_addr = 32'h500; req_valid = 1'b1;
    cyc(); cyc();
    dwait = 1'b1;
    cyc();
    #1; nRST = 1'b0; #1;
    chk("t7_rst_dREN", 32'(dREN), 32'd0);
    chk("t7_rst_cctrans", 32'(cctrans), 32'd0);
    chk("t7_rst_daddr", daddr, 32'd0);
    chk("t7_rst_fill_d0", fill_d0, 32'd0);
    nbad = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      if (req_done) nbad++;
      cyc();
    end
    chk("t7_no_done_in_reset", 32'(nbad), 32'd0);
    nRST = 1'b1; dwait = 1'b0; refresh();
    wait_done(20, n);
    chk("t7_latency", 32'(n), 32'd3);
    chk("t7_fill_d0", fill_d0, 32'hEEEE0000);
    cyc(); cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
